// File: rtl/apb_ram_wait.sv
// APB4 slave RAM with programmable wait states, byte strobes and error response.
// Latency: setup + WAIT_STATES+1 access cycles; outputs registered.
// Backpressure: pready held low for WAIT_STATES access cycles; psel drop abandons the transfer.
module apb_ram_wait #(
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH       = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int WAIT_STATES = 0
) (
  input  logic                    pclk,
  input  logic                    preset,
  input  logic                    psel,
  input  logic                    penable,
  input  logic                    pwrite,
  input  logic [ADDR_WIDTH-1:0]   paddr,
  input  logic [DATA_WIDTH-1:0]   pwdata,
  input  logic [DATA_WIDTH/8-1:0] pstrb,
  output logic [DATA_WIDTH-1:0]   prdata,
  output logic                    pready,
  output logic                    pslverr
);
  localparam int NB  = DATA_WIDTH / 8;
  localparam int LSB = $clog2(NB);
  localparam int IW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW  = 4;
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'((1 << LSB) - 1);
  localparam logic [ADDR_WIDTH-1:0] DEPTH_A    = ADDR_WIDTH'(DEPTH);
  localparam logic [CW-1:0]         CNT_INIT   = CW'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t                state, state_nxt;
  logic [CW-1:0]         cnt, cnt_nxt;
  logic [IW-1:0]         idx_q;
  logic                  write_q, err_q;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [ADDR_WIDTH-1:0] widx;
  logic                  setup, setup_err;
  logic                  load_resp, clr, commit;
  logic [IW-1:0]         resp_idx;
  logic                  resp_wr, resp_err;
  logic [DATA_WIDTH-1:0] resp_rdata;

  assign widx      = paddr >> LSB;
  assign setup     = psel & ~penable;
  assign setup_err = ((paddr & ALIGN_MASK) != '0) || (widx >= DEPTH_A);

  // With zero wait states RESP is entered on the setup edge, so use the live bus.
  assign resp_idx   = (state == IDLE) ? widx[IW-1:0] : idx_q;
  assign resp_wr    = (state == IDLE) ? pwrite       : write_q;
  assign resp_err   = (state == IDLE) ? setup_err    : err_q;
  assign resp_rdata = (!resp_wr && !resp_err) ? mem[resp_idx] : '0;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    load_resp = 1'b0;
    clr       = 1'b0;
    commit    = 1'b0;
    unique case (state)
      IDLE: begin
        if (setup) begin
          if (WAIT_STATES == 0) begin
            state_nxt = RESP;
            load_resp = 1'b1;
          end else begin
            state_nxt = WAIT;
            cnt_nxt   = CNT_INIT;
          end
        end
      end
      WAIT: begin
        if (!psel) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
          clr       = 1'b1;
        end else if (cnt == '0) begin
          state_nxt = RESP;
          load_resp = 1'b1;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      RESP: begin
        if (!psel) begin
          state_nxt = IDLE;
          clr       = 1'b1;
        end else if (penable && pready) begin
          state_nxt = IDLE;
          clr       = 1'b1;
          commit    = write_q && !err_q;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      state   <= IDLE;
      cnt     <= '0;
      idx_q   <= '0;
      write_q <= 1'b0;
      err_q   <= 1'b0;
      pready  <= 1'b0;
      pslverr <= 1'b0;
      prdata  <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (state == IDLE && setup) begin
        idx_q   <= widx[IW-1:0];
        write_q <= pwrite;
        err_q   <= setup_err;
      end
      if (load_resp) begin
        pready  <= 1'b1;
        pslverr <= resp_err;
        prdata  <= resp_rdata;
      end else if (clr) begin
        pready  <= 1'b0;
        pslverr <= 1'b0;
        prdata  <= '0;
      end
    end
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (commit) begin
      for (int b = 0; b < NB; b++)
        if (pstrb[b]) mem[idx_q][8*b +: 8] <= pwdata[8*b +: 8];
    end
  end
endmodule

// File: tb/tb_apb_ram_wait.sv
// Directed bench for apb_ram_wait: three instances with 0, 2 and 3 wait states.
module tb_apb_ram_wait;
  logic        pclk = 1'b0;
  logic        preset = 1'b1;
  logic        psel[3], penable[3], pwrite[3];
  logic [31:0] paddr[3], pwdata[3], prdata[3];
  logic [3:0]  pstrb[3];
  logic        pready[3], pslverr[3];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 pclk = ~pclk;

  apb_ram_wait #(.DATA_WIDTH(32), .DEPTH(32), .ADDR_WIDTH(32), .WAIT_STATES(0)) u_ws0 (
    .pclk(pclk), .preset(preset), .psel(psel[0]), .penable(penable[0]), .pwrite(pwrite[0]),
    .paddr(paddr[0]), .pwdata(pwdata[0]), .pstrb(pstrb[0]), .prdata(prdata[0]),
    .pready(pready[0]), .pslverr(pslverr[0]));
  apb_ram_wait #(.DATA_WIDTH(32), .DEPTH(32), .ADDR_WIDTH(32), .WAIT_STATES(2)) u_ws2 (
    .pclk(pclk), .preset(preset), .psel(psel[1]), .penable(penable[1]), .pwrite(pwrite[1]),
    .paddr(paddr[1]), .pwdata(pwdata[1]), .pstrb(pstrb[1]), .prdata(prdata[1]),
    .pready(pready[1]), .pslverr(pslverr[1]));
  apb_ram_wait #(.DATA_WIDTH(32), .DEPTH(32), .ADDR_WIDTH(32), .WAIT_STATES(3)) u_ws3 (
    .pclk(pclk), .preset(preset), .psel(psel[2]), .penable(penable[2]), .pwrite(pwrite[2]),
    .paddr(paddr[2]), .pwdata(pwdata[2]), .pstrb(pstrb[2]), .prdata(prdata[2]),
    .pready(pready[2]), .pslverr(pslverr[2]));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic check_idle_outs(input int d, input string tag);
    check({tag, ":pready"},  {31'd0, pready[d]},  32'd0);
    check({tag, ":pslverr"}, {31'd0, pslverr[d]}, 32'd0);
    check({tag, ":prdata"},  prdata[d],           32'd0);
  endtask

  // Called at a negedge; returns at the negedge after the completion edge with psel low.
  task automatic xfer(input int d, input bit wr, input logic [31:0] addr, input logic [31:0] wd,
                      input logic [3:0] st, input int exp_w, input logic [31:0] exp_rd,
                      input bit exp_err, input string tag);
    int w;
    psel[d] = 1'b1; penable[d] = 1'b0; pwrite[d] = wr;
    paddr[d] = addr; pwdata[d] = wd; pstrb[d] = st;
    @(posedge pclk); @(negedge pclk);
    penable[d] = 1'b1;
    w = 0;
    while (pready[d] !== 1'b1 && w < 40) begin
      @(posedge pclk); @(negedge pclk);
      w++;
    end
    check({tag, ":waits"},   32'(w),              32'(exp_w));
    check({tag, ":prdata"},  prdata[d],           exp_rd);
    check({tag, ":pslverr"}, {31'd0, pslverr[d]}, {31'd0, exp_err});
    @(posedge pclk); @(negedge pclk);
    psel[d] = 1'b0; penable[d] = 1'b0;
    check({tag, ":ready_drop"}, {31'd0, pready[d]}, 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      psel[i] = 1'b0; penable[i] = 1'b0; pwrite[i] = 1'b0;
      paddr[i] = '0; pwdata[i] = '0; pstrb[i] = '0;
    end
    repeat (3) @(posedge pclk);
    @(negedge pclk);
    preset = 1'b0;
    for (int i = 0; i < 3; i++) check_idle_outs(i, "reset");

    // Zero wait states, back-to-back write then read.
    xfer(0, 1, 32'h08, 32'hDEADBEEF, 4'hF, 0, 32'h0, 0, "ws0_wr08");
    xfer(0, 0, 32'h08, 32'h0, 4'h0, 0, 32'hDEADBEEF, 0, "ws0_rd08");

    // Partial strobes.
    xfer(0, 1, 32'h0C, 32'h11223344, 4'hF, 0, 32'h0, 0, "strb_full");
    xfer(0, 1, 32'h0C, 32'hAABBCCDD, 4'b0101, 0, 32'h0, 0, "strb_part");
    xfer(0, 0, 32'h0C, 32'h0, 4'h0, 0, 32'h11BB33DD, 0, "strb_rd");

    // Zero strobe write leaves the word alone.
    xfer(0, 1, 32'h08, 32'h01234567, 4'h0, 0, 32'h0, 0, "strb0_wr");
    xfer(0, 0, 32'h08, 32'h0, 4'h0, 0, 32'hDEADBEEF, 0, "strb0_rd");

    // Range and alignment errors.
    xfer(0, 1, 32'h7C, 32'h77777777, 4'hF, 0, 32'h0, 0, "pre_wr7c");
    xfer(0, 1, 32'h04, 32'h44444444, 4'hF, 0, 32'h0, 0, "pre_wr04");
    xfer(0, 1, 32'h80, 32'h99999999, 4'hF, 0, 32'h0, 1, "err_wr80");
    xfer(0, 1, 32'h06, 32'h99999999, 4'hF, 0, 32'h0, 1, "err_wr06");
    xfer(0, 0, 32'h06, 32'h0, 4'h0, 0, 32'h0, 1, "err_rd06");
    xfer(0, 0, 32'h7C, 32'h0, 4'h0, 0, 32'h77777777, 0, "post_rd7c");
    xfer(0, 0, 32'h04, 32'h0, 4'h0, 0, 32'h44444444, 0, "post_rd04");
    xfer(0, 0, 32'h00, 32'h0, 4'h0, 0, 32'h0, 0, "post_rd00");

    // Setup phase with penable already high is ignored.
    psel[0] = 1'b1; penable[0] = 1'b1; pwrite[0] = 1'b1; paddr[0] = 32'h08; pwdata[0] = 32'h0BAD0BAD; pstrb[0] = 4'hF;
    repeat (2) begin
      @(posedge pclk); @(negedge pclk);
      check("viol:pready", {31'd0, pready[0]}, 32'd0);
    end
    psel[0] = 1'b0; penable[0] = 1'b0;
    xfer(0, 0, 32'h08, 32'h0, 4'h0, 0, 32'hDEADBEEF, 0, "viol_rd08");

    // Abandon in RESP (zero wait): psel drops before completion.
    psel[0] = 1'b1; penable[0] = 1'b0; pwrite[0] = 1'b1; paddr[0] = 32'h08; pwdata[0] = 32'hFFFFFFFF; pstrb[0] = 4'hF;
    @(posedge pclk); @(negedge pclk);
    check("abresp:pready", {31'd0, pready[0]}, 32'd1);
    psel[0] = 1'b0;
    @(posedge pclk); @(negedge pclk);
    check_idle_outs(0, "abresp_idle");
    xfer(0, 0, 32'h08, 32'h0, 4'h0, 0, 32'hDEADBEEF, 0, "abresp_rd08");

    // Two wait states: fresh read returns zero on the third access cycle.
    xfer(1, 0, 32'h04, 32'h0, 4'h0, 2, 32'h0, 0, "ws2_rd04");

    // Three wait states: abandon a write after one access cycle.
    xfer(2, 1, 32'h10, 32'h5A5A1234, 4'hF, 3, 32'h0, 0, "ws3_wr10");
    psel[2] = 1'b1; penable[2] = 1'b0; pwrite[2] = 1'b1; paddr[2] = 32'h10; pwdata[2] = 32'hFFFF0000; pstrb[2] = 4'hF;
    @(posedge pclk); @(negedge pclk);
    penable[2] = 1'b1;
    check("ab:pready_acc1", {31'd0, pready[2]}, 32'd0);
    @(posedge pclk); @(negedge pclk);
    psel[2] = 1'b0; penable[2] = 1'b0;
    repeat (4) begin
      @(posedge pclk); @(negedge pclk);
      check("ab:pready_after", {31'd0, pready[2]}, 32'd0);
    end
    xfer(2, 0, 32'h10, 32'h0, 4'h0, 3, 32'h5A5A1234, 0, "ab_rd10");

    // Reset during the WAIT of a write.
    xfer(1, 1, 32'h04, 32'hCAFEF00D, 4'hF, 2, 32'h0, 0, "ws2_wr04");
    xfer(1, 1, 32'h7C, 32'h12345678, 4'hF, 2, 32'h0, 0, "ws2_wr7c");
    psel[1] = 1'b1; penable[1] = 1'b0; pwrite[1] = 1'b1; paddr[1] = 32'h08; pwdata[1] = 32'h87654321; pstrb[1] = 4'hF;
    @(posedge pclk); @(negedge pclk);
    penable[1] = 1'b1;
    @(posedge pclk); @(negedge pclk);
    preset = 1'b1;
    @(posedge pclk); @(negedge pclk);
    preset = 1'b0;
    psel[1] = 1'b0; penable[1] = 1'b0;
    check_idle_outs(1, "rstwait");
    @(posedge pclk); @(negedge pclk);
    check("rstwait:pready_hold", {31'd0, pready[1]}, 32'd0);
    for (int i = 0; i < 32; i++)
      xfer(1, 0, 32'(i * 4), 32'h0, 4'h0, 2, 32'h0, 0, $sformatf("clr%0d", i));
    xfer(0, 0, 32'h08, 32'h0, 4'h0, 0, 32'h0, 0, "clr_ws0_08");
    xfer(2, 0, 32'h10, 32'h0, 4'h0, 3, 32'h0, 0, "clr_ws3_10");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/apb_ram_wait.md
Name: apb_ram_wait

Overview:
Parametrised APB4 slave RAM, successor to the team's fixed 32x32 APB RAM. Generalised data width, depth and address width. Adds programmable wait states, byte-lane write strobes, misalignment and range error detection, and clean handling of abandoned transfers. Sits on the peripheral APB segment as a scratch/config memory; single clock domain.

Parameters:
DATA_WIDTH, 32, data bus width in bits; multiple of 8, range 8..128
DEPTH, 32, number of DATA_WIDTH words; need not be a power of two
ADDR_WIDTH, 32, paddr width in bits; byte addressing
WAIT_STATES, 0, number of access-phase cycles with pready low before completion; range 0..15

Ports:
pclk  in  1  clock; all logic on rising edge
preset  in  1  reset, synchronous, active-high
psel  in  1  slave select
penable  in  1  high in access phase
pwrite  in  1  1 = write, 0 = read
paddr  in  ADDR_WIDTH  byte address
pwdata  in  DATA_WIDTH  write data
pstrb  in  DATA_WIDTH/8  write byte-lane enables; ignored on reads
prdata  out  DATA_WIDTH  read data; valid only while pready=1 on a read
pready  out  1  transfer completes on an edge where psel & penable & pready
pslverr  out  1  error response; valid only while pready=1

Behaviour:
- Reset (preset=1 at an edge): state IDLE, prdata=0, pready=0, pslverr=0, wait counter=0, all DEPTH words cleared to 0. Reset overrides any transfer in flight; no write commits on that edge.
- Outputs are registered; there is no combinational path from inputs to outputs.
- Word index = paddr >> log2(DATA_WIDTH/8).
- Error condition, evaluated on the setup edge:
  - low log2(DATA_WIDTH/8) paddr bits are nonzero (misaligned), or
  - word index >= DEPTH.
- FSM states: IDLE, WAIT, RESP.
- IDLE: on an edge with psel=1, penable=0 (setup phase):
  - latch paddr, pwrite and the error flag.
  - If WAIT_STATES=0: go to RESP, pready<=1, and load pslverr and prdata (read data or 0) for the first access cycle. Zero-wait completion is therefore 2 cycles (setup + 1 access).
  - Else: counter<=WAIT_STATES-1, go to WAIT.
- WAIT: each edge with psel=1:
  - if counter=0: go to RESP, pready<=1, load pslverr/prdata.
  - else: counter decrements.
  - Total access-phase length = WAIT_STATES+1 cycles.
- RESP: on an edge with psel & penable & pready, the transfer completes:
  - Write without error: commit pwdata bytes where pstrb[i]=1; other bytes unchanged.
  - pready<=0, pslverr<=0, prdata<=0, go to IDLE.
- Read with error: prdata=0 (never X). Write with error: memory untouched.
- Read data is sampled from memory at the RESP-entry edge.
- Abandon: psel=0 while in WAIT or RESP → go to IDLE, outputs cleared, no write.
- Back-to-back: the completion cycle returns to IDLE. A new setup phase may occur the very next cycle; no dead cycle is required beyond APB's own setup phase.
- Setup phase with penable=1 while in IDLE is a protocol violation: ignored, state stays IDLE.
- pstrb=0 on a write: completes normally, no byte changes, pslverr=0.

Test Plan:
- DW=32, WS=0: write 0xDEADBEEF to 0x08, pstrb=0xF, then read 0x08 → pready high in the first access cycle each time, prdata=0xDEADBEEF, pslverr=0.
- DW=32, WS=2: read 0x04 after reset → pready low for 2 access cycles, high on the 3rd, prdata=0x00000000.
- Partial strobes: write 0x11223344 to 0x0C, then write 0xAABBCCDD with pstrb=0b0101 → read returns 0x11BB33DD.
- Errors at DEPTH=32: write to 0x80 (index 32) and read from 0x06 (misaligned) → pslverr=1 with pready, prdata=0, memory unchanged (read 0x7C and 0x04 both still return prior values).
- Abandon: WS=3, start a write to 0x10, drop psel after 1 access cycle → state IDLE, pready never asserted, a later read of 0x10 returns its old value.
- Reset mid-wait: assert preset during WAIT of a write → pready=0, pslverr=0, prdata=0, all words read back as 0.
